// File: rtl/text_pixel_pipe.sv
// Three-stage text pixel pipeline: font ROM address, ROM-aligned glyph bit select, and a registered colour stage.
// Optional frame-counted blink of lit pixels is enabled by defining TEXT_PIXEL_BLINK_EN.
module text_pixel_pipe #(
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter int          BLINK_FRAMES = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        is_text,
    input  logic [10:0] sprite_addr,
    input  logic [2:0]  glyph_col,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        text_on,
    output logic        text_valid,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue
);

    logic [10:0] font_addr_q;
    logic        s1_is_text_q, s2_is_text_q;
    logic [2:0]  s1_col_q, s2_col_q;
    logic        text_on_q, text_on_d;
    logic        text_valid_q, text_valid_d;
    logic [23:0] rgb_q, rgb_d;
    logic        pix_lit;
    logic        vis;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            font_addr_q  <= '0;
            s1_is_text_q <= 1'b0;
            s1_col_q     <= '0;
            s2_is_text_q <= 1'b0;
            s2_col_q     <= '0;
            text_on_q    <= 1'b0;
            text_valid_q <= 1'b0;
            rgb_q        <= '0;
        end else begin
            font_addr_q  <= sprite_addr;
            s1_is_text_q <= is_text;
            s1_col_q     <= glyph_col;
            s2_is_text_q <= s1_is_text_q;
            s2_col_q     <= s1_col_q;
            text_on_q    <= text_on_d;
            text_valid_q <= text_valid_d;
            rgb_q        <= rgb_d;
        end
    end

    // Column 0 is the leftmost pixel, held in bit 7; for a 3-bit column, 7 - col == ~col.
    always_comb begin
        pix_lit      = font_data[~s2_col_q];
        text_valid_d = s2_is_text_q;
        text_on_d    = s2_is_text_q & pix_lit & vis;
        rgb_d        = 24'h0;
        if (text_on_d) begin
            rgb_d = FG_RGB;
        end else if (text_valid_d) begin
            rgb_d = BG_RGB;
        end
    end

`ifdef TEXT_PIXEL_BLINK_EN
    typedef enum logic {
        SHOW = 1'b0,
        HIDE = 1'b1
    } blink_state_e;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    blink_state_e state_q, state_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         sync1_q, sync2_q, edge_q;
    logic [2:0]   prime_q;
    logic         frame_tick;

    // prime_q marks when edge_q holds a genuine post-reset sample, so a
    // frame_clk already high at release is not mistaken for a rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    assign frame_tick = prime_q[2] & sync2_q & ~edge_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= SHOW;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = '0;
                state_d     = (state_q == SHOW) ? HIDE : SHOW;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    assign vis = (state_q == SHOW);
`else
    logic unused_blink;

    assign vis          = 1'b1;
    assign unused_blink = ^{frame_clk, 8'(BLINK_FRAMES)};
`endif

    assign font_addr  = font_addr_q;
    assign text_on    = text_on_q;
    assign text_valid = text_valid_q;
    assign Red        = rgb_q[23:16];
    assign Green      = rgb_q[15:8];
    assign Blue       = rgb_q[7:0];

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Scoreboard bench for text_pixel_pipe: a driver pushes expected pixels computed from a
// font-ROM model, and a monitor pops and compares them when each falls due.
module tb_text_pixel_pipe;

  localparam logic [23:0] FG    = 24'hFFFFFF;
  localparam logic [23:0] BG    = 24'h123456;
  localparam int          BLINK = 2;

  logic        Clk;
  logic        Reset_n;
  logic        frame_clk;
  logic        is_text;
  logic [10:0] sprite_addr;
  logic [2:0]  glyph_col;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        text_on;
  logic        text_valid;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;

  text_pixel_pipe #(
    .FG_RGB      (FG),
    .BG_RGB      (BG),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .is_text    (is_text),
    .sprite_addr(sprite_addr),
    .glyph_col  (glyph_col),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .text_on    (text_on),
    .text_valid (text_valid),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  // ---------------- clock / reset / ROM ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  logic [7:0] rom [2048];
  always @(posedge Clk) font_data <= rom[font_addr];

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  int          exp_due_q[$];
  logic [10:0] addr_q[$];
  int          addr_due_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ticks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_vis();
`ifdef TEXT_PIXEL_BLINK_EN
    return ((ticks / BLINK) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // {text_valid, text_on, rgb} for one pixel, from the ROM contents and glyph column.
  function automatic logic [25:0] model_pix(input logic it, input logic [10:0] a, input logic [2:0] c);
    logic [7:0]  row;
    logic        lit;
    logic        on;
    logic [23:0] rgb;
    row = rom[a];
    lit = ((row >> (7 - int'(c))) & 8'd1) != 8'd0;
    on  = it && lit && model_vis();
    rgb = on ? FG : (it ? BG : 24'h0);
    return {it, on, rgb};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_pix(input logic it, input logic [10:0] a, input logic [2:0] c);
    @(posedge Clk);
    #1;
    is_text     = it;
    sprite_addr = a;
    glyph_col   = c;
    addr_q.push_back(a);
    addr_due_q.push_back(edge_cnt + 1);
    exp_q.push_back(model_pix(it, a, c));
    exp_due_q.push_back(edge_cnt + 3);
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pix($urandom_range(0, 3) != 0, 11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_pix(1'b0, 11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)));
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    drive_idle(4);
    frame_clk = 1'b0;
    drive_idle(6);
    ticks++;
  endtask

  task automatic lit_row(input logic [10:0] a);
    for (int c = 0; c < 8; c++) drive_pix(1'b1, a, 3'(c));
  endtask

  task automatic do_reset(input logic frame_level);
    @(posedge Clk);
    #2;
    frame_clk   = frame_level;
    Reset_n     = 1'b0;
    is_text     = 1'b1;
    sprite_addr = 11'h7FF;
    glyph_col   = 3'd0;
    exp_q.delete();
    exp_due_q.delete();
    addr_q.delete();
    addr_due_q.delete();
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("reset_out", {6'd0, text_valid, text_on, Red, Green, Blue}, 32'd0);
      check("reset_addr", {21'd0, font_addr}, 32'd0);
      @(posedge Clk);
    end
    #1;
    Reset_n = 1'b1;
    is_text = 1'b0;
    // Nothing in flight survives reset: the first two outputs after release are blank.
    exp_q.push_back(26'd0);
    exp_due_q.push_back(edge_cnt + 1);
    exp_q.push_back(26'd0);
    exp_due_q.push_back(edge_cnt + 2);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (addr_due_q.size() > 0 && addr_due_q[0] <= edge_cnt) begin
        check("font_addr_due", 32'(addr_due_q[0]), 32'(edge_cnt));
        check("font_addr", {21'd0, font_addr}, {21'd0, addr_q[0]});
        void'(addr_q.pop_front());
        void'(addr_due_q.pop_front());
      end
      if (exp_due_q.size() > 0 && exp_due_q[0] <= edge_cnt) begin
        check("pixel_due", 32'(exp_due_q[0]), 32'(edge_cnt));
        check("pixel", {6'd0, text_valid, text_on, Red, Green, Blue}, {6'd0, exp_q[0]});
        void'(exp_q.pop_front());
        void'(exp_due_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset_n     = 1'b0;
    frame_clk   = 1'b0;
    is_text     = 1'b0;
    sprite_addr = '0;
    glyph_col   = '0;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[11'h500] = 8'h80;
    rom[11'h101] = 8'h01;
    rom[11'h2A5] = 8'hA5;
    rom[11'h7FF] = 8'hFF;

    do_reset(1'b0);

    drive_pix(1'b1, 11'h500, 3'd0);
    drive_idle(2);
    drive_pix(1'b1, 11'h101, 3'd7);
    drive_pix(1'b1, 11'h101, 3'd6);
    lit_row(11'h2A5);
    drive_idle(3);
    drive_random(200);

`ifdef TEXT_PIXEL_BLINK_EN
    for (int p = 0; p < 5; p++) begin
      lit_row(11'h7FF);
      lit_row(11'h2A5);
      if (p < 4) frame_pulse();
    end
    drive_random(20);
    do_reset(1'b1);
    drive_idle(4);
    frame_clk = 1'b0;
    drive_idle(4);
    frame_pulse();
    lit_row(11'h7FF);
`else
    for (int i = 0; i < 20; i++) begin
      drive_pix(1'b1, 11'h2A5, 3'(i % 8));
      frame_clk = ~frame_clk;
    end
    drive_random(20);
    do_reset(1'b1);
    drive_idle(2);
    lit_row(11'h7FF);
`endif

    drive_random(100);
    repeat (6) @(posedge Clk);
    #1;
    check("drain_pixels", 32'(exp_q.size()), 32'd0);
    check("drain_addr", 32'(addr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_pixel_pipe.md
TEXT_PIXEL_PIPE -- requirements
Module: text_pixel_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FG_RGB, 24'hFFFFFF, glyph foreground colour
- BG_RGB, 24'h000000, colour when a text pixel is off
- BLINK_FRAMES, 32, frames per blink half-period, range 1..255

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, pixel clock
- Reset_n, in, 1, asynchronous active-low reset
- frame_clk, in, 1, vertical sync, level signal
- is_text, in, 1, OR of all label-decoder hit flags for the current DrawX/DrawY
- sprite_addr, in, 11, font ROM row address from the hitting label decoder
- glyph_col, in, 3, column inside the glyph (DrawX minus label start_x, mod 8)
- font_addr, out, 11, address to the external synchronous font ROM
- font_data, in, 8, ROM row, valid 1 cycle after font_addr; bit 7 is the leftmost pixel
- text_on, out, 1, current pipelined pixel is a lit glyph pixel
- text_valid, out, 1, current pipelined pixel lies inside a label box
- Red, Green, Blue, out, 8 each, pixel colour

Function
REQ-003 Stage 0 SHALL register sprite_addr into font_addr, and is_text and glyph_col into s1 registers, every Clk.
REQ-004 Stage 1 SHALL register the s1 registers into s2 registers, aligned with font_data arrival.
REQ-005 Stage 2 SHALL register outputs: text_valid = s2_is_text; text_on = s2_is_text & font_data[7 - s2_col] & vis.
REQ-006 Total latency SHALL be exactly 2 Clk from is_text/sprite_addr/glyph_col to text_on/text_valid/RGB.
REQ-007 {Red,Green,Blue} SHALL be FG_RGB when text_on=1, BG_RGB when text_valid=1 and text_on=0, and 24'h0 otherwise.
REQ-008 When is_text=0 the font_addr value is don't-care to the consumer, but SHALL still be registered from sprite_addr (no hold).
REQ-009 frame_clk SHALL be sampled into a 2-flop synchroniser plus one edge flop; a frame tick is a 0->1 transition of the synchronised signal.
REQ-010 Blink state machine: states SHOW and HIDE; vis=1 in SHOW, vis=0 in HIDE; an 8-bit frame counter increments on each frame tick.
REQ-011 When the counter reaches BLINK_FRAMES-1 on a tick, it SHALL wrap to 0 and the state SHALL toggle; this gives a half-period of exactly BLINK_FRAMES frames.
REQ-012 A state change SHALL take effect for pixels entering stage 2 on the cycle after the tick; a frame in progress may change mid-line, and this is accepted.
REQ-013 text_valid SHALL be independent of vis; BG_RGB is still drawn inside label boxes during HIDE.

Reset
REQ-014 While Reset_n=0 (asynchronous assert): font_addr=0, all s1/s2 registers=0, text_on=0, text_valid=0, RGB=0, synchroniser flops=0, counter=0, state=SHOW.
REQ-015 Release SHALL be synchronous-safe. The first valid output SHALL appear 2 Clk after the first sampled input following deassertion.
REQ-016 Reset mid-frame SHALL discard in-flight pixels. No frame tick SHALL be generated by the release itself, even if frame_clk=1.

Configuration
REQ-017 Macro TEXT_PIXEL_BLINK_EN: when defined, REQ-009..REQ-012 are implemented as stated.
REQ-018 When TEXT_PIXEL_BLINK_EN is undefined, vis is constant 1 and no synchroniser, counter or state registers are synthesised. frame_clk remains a port and is unused. Pipeline latency is unchanged.

Verification
REQ-019 Reset: hold Reset_n=0 with is_text=1 -> text_on=0, text_valid=0, RGB=0, font_addr=0.
REQ-020 Latency: cycle N drives is_text=1, sprite_addr=11'h500, glyph_col=0; cycle N+1 returns font_data=8'h80 -> font_addr=11'h500 after edge N; text_on=1 and RGB=FFFFFF after edge N+2.
REQ-021 Bit select: font_data=8'h01 with glyph_col=7 -> text_on=1; with glyph_col=6 -> text_on=0 and RGB=000000 with text_valid=1.
REQ-022 Back-to-back: 8 consecutive columns with font_data=8'hA5 -> text_on sequence 1,0,1,0,0,1,0,1, starting 2 cycles after the first input, with no bubbles.
REQ-023 Blink (macro defined, BLINK_FRAMES=2): apply 4 frame_clk pulses -> vis 1,1,0,0,1 across the ticks. During HIDE, text_on=0 while text_valid=1.
REQ-024 Blink (macro undefined): toggle frame_clk 10 times -> text_on follows font_data continuously.
